// File: rtl/ahb_lite_cmd_master.sv
// rtl/ahb_lite_cmd_master.sv - AHB-Lite single-beat initiator fed by a valid/ready command port
// Address and data phases are pipelined; responses return through a small FIFO.
module ahb_lite_cmd_master #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int RSP_DEPTH = 4
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [2:0]        cmd_size,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic [ADDR_W-1:0] HADDR,
   output logic              HWRITE,
   output logic [1:0]        HTRANS,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic [3:0]        HPROT,
   output logic              HMASTLOCK,
   output logic [DATA_W-1:0] HWDATA,
   input  logic              HREADY,
   input  logic              HRESP,
   input  logic [DATA_W-1:0] HRDATA
);
   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int OW = $clog2(RSP_DEPTH + 3);

   logic              r_ap_valid;
   logic              r_ap_write;
   logic [ADDR_W-1:0] r_ap_addr;
   logic [2:0]        r_ap_size;
   logic [DATA_W-1:0] r_ap_wdata;
   logic              r_dp_valid;
   logic              r_dp_write;
   logic [DATA_W-1:0] r_dp_wdata;
   logic              r_err_hold;

   logic [DATA_W-1:0] r_fifo_rdata [RSP_DEPTH];
   logic [RSP_DEPTH-1:0] r_fifo_err;
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [OW-1:0]     r_rsp_count;

   logic [OW-1:0]     w_occ;
   logic              w_accept;
   logic              w_ap_done;
   logic              w_dp_done;
   logic              w_push;
   logic              w_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Counting everything in flight against the FIFO depth means every
   // data-phase completion is guaranteed a free response slot.
   assign w_occ     = {{(OW-1){1'b0}}, r_ap_valid} + {{(OW-1){1'b0}}, r_dp_valid} + r_rsp_count;
   assign cmd_ready = (!r_ap_valid | HREADY) & (w_occ < OW'(RSP_DEPTH)) & !r_err_hold;
   assign w_accept  = cmd_valid & cmd_ready;
   assign w_ap_done = r_ap_valid & !r_err_hold & HREADY;
   assign w_dp_done = r_dp_valid & HREADY;
   assign w_push    = w_dp_done;
   assign w_pop     = rsp_valid & rsp_ready;

   assign HTRANS    = (r_ap_valid & !r_err_hold) ? 2'b10 : 2'b00;
   assign HADDR     = r_ap_addr;
   assign HWRITE    = r_ap_write;
   assign HSIZE     = r_ap_size;
   assign HWDATA    = r_dp_wdata;
   assign HBURST    = 3'b000;
   assign HPROT     = 4'b0011;
   assign HMASTLOCK = 1'b0;

   assign rsp_valid = (r_rsp_count != '0);
   assign rsp_rdata = r_fifo_rdata[r_rd_ptr];
   assign rsp_err   = r_fifo_err[r_rd_ptr];
   assign busy      = (w_occ != '0);

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_ap_valid <= 1'b0;
         r_ap_write <= 1'b0;
         r_ap_addr  <= '0;
         r_ap_size  <= '0;
         r_ap_wdata <= '0;
         r_dp_valid <= 1'b0;
         r_dp_write <= 1'b0;
         r_dp_wdata <= '0;
         r_err_hold <= 1'b0;
      end else begin
         if (w_accept) begin
            r_ap_valid <= 1'b1;
            r_ap_write <= cmd_write;
            r_ap_addr  <= cmd_addr;
            r_ap_size  <= cmd_size;
            r_ap_wdata <= cmd_wdata;
         end else if (w_ap_done) begin
            r_ap_valid <= 1'b0;
         end

         if (w_ap_done) begin
            r_dp_valid <= 1'b1;
            r_dp_write <= r_ap_write;
            r_dp_wdata <= r_ap_wdata;
         end else if (w_dp_done) begin
            r_dp_valid <= 1'b0;
         end

         // First ERROR cycle parks the pending address phase; it is released
         // once the error's second cycle completes.
         if (r_dp_valid & HRESP & !HREADY) begin
            r_err_hold <= 1'b1;
         end else if (w_dp_done) begin
            r_err_hold <= 1'b0;
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         for (int i = 0; i < RSP_DEPTH; i++) begin
            r_fifo_rdata[i] <= '0;
         end
         r_fifo_err  <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_rsp_count <= '0;
      end else begin
         if (w_push) begin
            r_fifo_rdata[r_wr_ptr] <= r_dp_write ? '0 : HRDATA;
            r_fifo_err[r_wr_ptr]   <= HRESP;
            r_wr_ptr               <= next_ptr(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_rsp_count <= r_rsp_count + OW'(1);
            2'b01:   r_rsp_count <= r_rsp_count - OW'(1);
            default: r_rsp_count <= r_rsp_count;
         endcase
      end
   end
endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// tb/tb_ahb_lite_cmd_master.sv - directed vector bench for ahb_lite_cmd_master
// Cycle table for single/wait-state transfers, then hand sequences for streaming, backpressure, ERROR and reset.
module tb_ahb_lite_cmd_master;
   localparam int DEPTH = 4;
   localparam logic [31:0] A = 32'h4000_0004;
   localparam logic [31:0] B = 32'h4000_0010;
   localparam logic [31:0] C = 32'h4000_0020;
   localparam logic [31:0] D = 32'h4000_0024;
   localparam int NV = 21;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [2:0]  cmd_size;
   logic        rsp_valid, rsp_ready, rsp_err, busy;
   logic [31:0] rsp_rdata;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic        HWRITE, HMASTLOCK, HREADY, HRESP;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;

   logic        use_model = 1'b0;
   logic [31:0] tb_hrdata;
   logic [31:0] slave_addr = 32'h0;
   logic        ovf = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic        cv;
      logic        cw;
      logic [31:0] ca;
      logic [31:0] cd;
      logic        hr;
      logic        hs;
      logic [31:0] hd;
      logic        rr;
      logic        e_ready;
      logic [1:0]  e_trans;
      logic [31:0] e_haddr;
      logic        e_hwrite;
      logic [31:0] e_hwdata;
      logic        e_rv;
      logic [31:0] e_rdata;
      logic        e_err;
      logic        e_busy;
   } vec_t;

   vec_t vt [NV];
   logic [31:0] exp_q [$];

   ahb_lite_cmd_master #(.ADDR_W(32), .DATA_W(32), .RSP_DEPTH(DEPTH)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy),
      .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
      .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
   );

   always #5 HCLK = ~HCLK;

   // Slave read data is a fixed function of the address captured in the address phase.
   assign HRDATA = use_model ? (32'h5A00_0000 ^ slave_addr) : tb_hrdata;

   always @(posedge HCLK) begin
      if (HREADY && HTRANS == 2'b10) slave_addr <= HADDR;
      if (!HRESET && dut.w_push && !dut.w_pop && int'(dut.r_rsp_count) == DEPTH) ovf <= 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic cv, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic hr, input logic hs, input logic [31:0] hd, input logic rr);
      cmd_valid = cv;
      cmd_write = cw;
      cmd_addr  = ca;
      cmd_wdata = cd;
      HREADY    = hr;
      HRESP     = hs;
      tb_hrdata = hd;
      rsp_ready = rr;
   endtask

   initial begin
      int n_acc;
      int n_rsp;
      //         cv    cw    ca     cd            hr    hs    hd            rr    rdy   tr     haddr hw    hwdata        rv    rdata         err   busy
      vt[0]  = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
      vt[1]  = '{1'b1, 1'b1, A,     32'h1,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
      vt[2]  = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'd2, A,     1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
      vt[3]  = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h1234_5678,1'b0, 1'b1, 2'd0, A,     1'b1, 32'h1,        1'b0, 32'h0,        1'b0, 1'b1};
      vt[4]  = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'd0, A,     1'b1, 32'h1,        1'b1, 32'h0,        1'b0, 1'b1};
      vt[5]  = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 2'd0, A,     1'b1, 32'h1,        1'b1, 32'h0,        1'b0, 1'b1};
      vt[6]  = '{1'b1, 1'b0, B,     32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'd0, A,     1'b1, 32'h1,        1'b0, 32'h0,        1'b0, 1'b0};
      vt[7]  = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'd2, B,     1'b0, 32'h1,        1'b0, 32'h0,        1'b0, 1'b1};
      vt[8]  = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'hDEAD_BEEF,1'b0, 1'b1, 2'd0, B,     1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
      vt[9]  = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 2'd0, B,     1'b0, 32'h0,        1'b1, 32'hDEAD_BEEF,1'b0, 1'b1};
      vt[10] = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'd0, B,     1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
      vt[11] = '{1'b1, 1'b1, C,     32'hCAFE_0001,1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'd0, B,     1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
      vt[12] = '{1'b1, 1'b0, D,     32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'd2, C,     1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
      vt[13] = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd2, D,     1'b0, 32'hCAFE_0001,1'b0, 32'h0,        1'b0, 1'b1};
      vt[14] = vt[13];
      vt[15] = vt[13];
      vt[16] = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'hFFFF_FFFF,1'b0, 1'b1, 2'd2, D,     1'b0, 32'hCAFE_0001,1'b0, 32'h0,        1'b0, 1'b1};
      vt[17] = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h0BAD_F00D,1'b0, 1'b1, 2'd0, D,     1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 1'b1};
      vt[18] = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 2'd0, D,     1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 1'b1};
      vt[19] = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 2'd0, D,     1'b0, 32'h0,        1'b1, 32'h0BAD_F00D,1'b0, 1'b1};
      vt[20] = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'd0, D,     1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};

      HRESET   = 1'b1;
      cmd_size = 3'd2;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge HCLK);
      @(negedge HCLK);
      #1;
      chk("rst_htrans", 32'(HTRANS), 32'h0);
      chk("rst_haddr", HADDR, 32'h0);
      chk("rst_hwrite", 32'(HWRITE), 32'h0);
      chk("rst_hsize", 32'(HSIZE), 32'h0);
      chk("rst_hwdata", HWDATA, 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("hburst", 32'(HBURST), 32'h0);
      chk("hprot", 32'(HPROT), 32'h3);
      chk("hmastlock", 32'(HMASTLOCK), 32'h0);
      @(negedge HCLK);
      HRESET = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(negedge HCLK);
         drive(vt[i].cv, vt[i].cw, vt[i].ca, vt[i].cd, vt[i].hr, vt[i].hs, vt[i].hd, vt[i].rr);
         #1;
         chk($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'(vt[i].e_ready));
         chk($sformatf("v%0d_htrans", i), 32'(HTRANS), 32'(vt[i].e_trans));
         chk($sformatf("v%0d_haddr", i), HADDR, vt[i].e_haddr);
         chk($sformatf("v%0d_hwrite", i), 32'(HWRITE), 32'(vt[i].e_hwrite));
         chk($sformatf("v%0d_hwdata", i), HWDATA, vt[i].e_hwdata);
         chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vt[i].e_rv));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
         if (vt[i].e_rv) begin
            chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vt[i].e_rdata);
            chk($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(vt[i].e_err));
         end
      end

      // Eight back-to-back reads at full rate.
      use_model = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge HCLK);
         drive(c < 8, 1'b0, 32'h4000_0100 + 32'(4 * c), 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
         #1;
         if (c < 8) chk("b2b_cmd_ready", 32'(cmd_ready), 32'h1);
         if (c >= 1 && c <= 8) begin
            chk("b2b_htrans", 32'(HTRANS), 32'h2);
            chk("b2b_haddr", HADDR, 32'h4000_0100 + 32'(4 * (c - 1)));
         end
         if (c >= 3 && c <= 10) begin
            chk("b2b_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("b2b_rsp_rdata", rsp_rdata, 32'h5A00_0000 ^ (32'h4000_0100 + 32'(4 * (c - 3))));
         end else begin
            chk("b2b_rsp_empty", 32'(rsp_valid), 32'h0);
         end
      end

      // Response backpressure: six reads offered, only DEPTH fit.
      n_acc = 0;
      n_rsp = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge HCLK);
         drive(n_acc < 6, 1'b0, 32'h4000_0200 + 32'(4 * n_acc), 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
         #1;
         if (cmd_valid && cmd_ready) begin
            exp_q.push_back(32'h5A00_0000 ^ cmd_addr);
            n_acc++;
         end
      end
      chk("bp_accepted", 32'(n_acc), 32'd4);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'h0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      for (int c = 0; c < 20 && n_rsp < 6; c++) begin
         @(negedge HCLK);
         drive(n_acc < 6, 1'b0, 32'h4000_0200 + 32'(4 * n_acc), 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
         #1;
         if (cmd_valid && cmd_ready) begin
            exp_q.push_back(32'h5A00_0000 ^ cmd_addr);
            n_acc++;
         end
         if (rsp_valid) begin
            if (exp_q.size() == 0) chk("bp_unexpected_rsp", rsp_rdata, 32'h0 ^ ~rsp_rdata);
            else chk("bp_rsp_rdata", rsp_rdata, exp_q.pop_front());
            n_rsp++;
         end
      end
      chk("bp_total_accepted", 32'(n_acc), 32'd6);
      chk("bp_total_rsp", 32'(n_rsp), 32'd6);
      @(negedge HCLK);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      chk("bp_idle_busy", 32'(busy), 32'h0);

      // Slave ERRORs the first of two reads.
      use_model = 1'b0;
      @(negedge HCLK);
      drive(1'b1, 1'b0, 32'h4000_0030, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge HCLK);
      drive(1'b1, 1'b0, 32'h4000_0034, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      chk("err_c1_htrans", 32'(HTRANS), 32'h2);
      chk("err_c1_haddr", HADDR, 32'h4000_0030);
      chk("err_c1_hsize", 32'(HSIZE), 32'h2);
      @(negedge HCLK);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
      #1;
      chk("err_first_htrans", 32'(HTRANS), 32'h2);
      chk("err_first_haddr", HADDR, 32'h4000_0034);
      chk("err_first_cmd_ready", 32'(cmd_ready), 32'h0);
      @(negedge HCLK);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0);
      #1;
      chk("err_second_htrans", 32'(HTRANS), 32'h0);
      chk("err_second_cmd_ready", 32'(cmd_ready), 32'h0);
      @(negedge HCLK);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      chk("err_reissue_htrans", 32'(HTRANS), 32'h2);
      chk("err_reissue_haddr", HADDR, 32'h4000_0034);
      chk("err_rsp_valid", 32'(rsp_valid), 32'h1);
      @(negedge HCLK);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h600D_DA7A, 1'b0);
      #1;
      chk("err_after_htrans", 32'(HTRANS), 32'h0);
      @(negedge HCLK);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      #1;
      chk("err_rsp0_err", 32'(rsp_err), 32'h1);
      @(negedge HCLK);
      #1;
      chk("err_rsp1_valid", 32'(rsp_valid), 32'h1);
      chk("err_rsp1_err", 32'(rsp_err), 32'h0);
      chk("err_rsp1_rdata", rsp_rdata, 32'h600D_DA7A);
      @(negedge HCLK);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      chk("err_done_busy", 32'(busy), 32'h0);

      // Reset mid-transfer with a response still queued.
      @(negedge HCLK);
      drive(1'b1, 1'b0, 32'h4000_0040, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge HCLK);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge HCLK);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1111_1111, 1'b0);
      @(negedge HCLK);
      drive(1'b1, 1'b0, 32'h4000_0044, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      chk("mrst_pre_rsp_valid", 32'(rsp_valid), 32'h1);
      @(negedge HCLK);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      chk("mrst_pre_htrans", 32'(HTRANS), 32'h2);
      #1;
      HRESET = 1'b1;
      #1;
      chk("mrst_htrans", 32'(HTRANS), 32'h0);
      chk("mrst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("mrst_busy", 32'(busy), 32'h0);
      chk("mrst_haddr", HADDR, 32'h0);
      @(negedge HCLK);
      HRESET = 1'b0;
      @(negedge HCLK);
      #1;
      chk("mrst_after_cmd_ready", 32'(cmd_ready), 32'h1);
      chk("mrst_after_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("mrst_after_htrans", 32'(HTRANS), 32'h0);

      chk("no_fifo_overflow", 32'(ovf), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
